// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier, the product accumulator and its consumer.
// The upstream/downstream side uses the master modport; the accumulator uses the slave modport.
interface product_accumulator_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int ACC_WIDTH   = 12,
  parameter int COUNT_WIDTH = 4
);
  logic                    productValid;
  logic                    productReady;
  logic [2*DATA_WIDTH-1:0] productValue;
  logic                    productLast;
  logic                    sumValid;
  logic                    sumReady;
  logic [ACC_WIDTH-1:0]    sumValue;
  logic [COUNT_WIDTH-1:0]  sumCount;
  logic                    sumOverflow;

  modport master (
    output productValid, productValue, productLast, sumReady,
    input  productReady, sumValid, sumValue, sumCount, sumOverflow
  );

  modport slave (
    input  productValid, productValue, productLast, sumReady,
    output productReady, sumValid, sumValue, sumCount, sumOverflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Accumulates a burst of multiplier products and presents sum, beat count and
// sticky overflow on a valid/ready result port.
module product_accumulator #(
  parameter int DATA_WIDTH  = 4,
  parameter int ACC_WIDTH   = 12,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  product_accumulator_if.slave  bus
);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]             state_reg, state_next;
  logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
  logic [COUNT_WIDTH-1:0] count_reg, count_next;
  logic                   overflow_reg, overflow_next;

  logic                   accept;
  logic [ACC_WIDTH:0]     prod_ext;
  logic [ACC_WIDTH:0]     sum_full;

  // Handshake outputs decode from state only, so no input-to-ready path exists.
  assign bus.productReady = (state_reg == ST_ACCUM);
  assign bus.sumValid     = (state_reg == ST_HOLD);
  assign bus.sumValue     = acc_reg;
  assign bus.sumCount     = count_reg;
  assign bus.sumOverflow  = overflow_reg;

  assign accept   = bus.productValid && (state_reg == ST_ACCUM);
  assign prod_ext = {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, bus.productValue};
  assign sum_full = {1'b0, acc_reg} + prod_ext;

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      ST_ACCUM: begin
        if (accept) begin
          acc_next      = sum_full[ACC_WIDTH-1:0];
          overflow_next = overflow_reg | sum_full[ACC_WIDTH];
          if (count_reg != {COUNT_WIDTH{1'b1}}) begin
            count_next = count_reg + COUNT_WIDTH'(1);
          end
          if (bus.productLast) begin
            state_next = ST_HOLD;
          end
        end
      end
      default: begin
        if (bus.sumReady) begin
          acc_next      = '0;
          count_next    = '0;
          overflow_next = 1'b0;
          state_next    = ST_ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_reg    <= ST_ACCUM;
      acc_reg      <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: hand-computed burst results,
// saturation/overflow, result back-pressure, idle garbage and mid-burst reset.
module tb_product_accumulator;
  logic clock;
  logic resetN;

  int n_cmp;
  int n_err;

  product_accumulator_if #(.DATA_WIDTH(4), .ACC_WIDTH(12), .COUNT_WIDTH(4)) bus ();

  product_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(12), .COUNT_WIDTH(4)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [7:0] value, input logic last);
    bus.productValid = 1'b1;
    bus.productValue = value;
    bus.productLast  = last;
    step();
    bus.productValid = 1'b0;
    bus.productValue = 8'd0;
    bus.productLast  = 1'b0;
    $display("beat value=%0d last=%0d", value, last);
  endtask

  task automatic check_result(input string tag, input int sum, input int cnt, input int ovf);
    $display("result %s: sum=%0d count=%0d ovf=%0d", tag, bus.sumValue, bus.sumCount, bus.sumOverflow);
    check({tag, ".valid"}, 32'(bus.sumValid), 32'd1);
    check({tag, ".ready"}, 32'(bus.productReady), 32'd0);
    check({tag, ".sum"},   32'(bus.sumValue), 32'(sum));
    check({tag, ".count"}, 32'(bus.sumCount), 32'(cnt));
    check({tag, ".ovf"},   32'(bus.sumOverflow), 32'(ovf));
  endtask

  task automatic take_result(input string tag);
    bus.sumReady = 1'b1;
    step();
    bus.sumReady = 1'b0;
    check({tag, ".ready_back"}, 32'(bus.productReady), 32'd1);
    check({tag, ".valid_drop"}, 32'(bus.sumValid), 32'd0);
    check({tag, ".sum_clr"},    32'(bus.sumValue), 32'd0);
    check({tag, ".count_clr"},  32'(bus.sumCount), 32'd0);
    check({tag, ".ovf_clr"},    32'(bus.sumOverflow), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetN           = 1'b0;
    bus.productValid = 1'b0;
    bus.productValue = 8'd0;
    bus.productLast  = 1'b0;
    bus.sumReady     = 1'b0;
    step();
    step();
    resetN = 1'b1;
    check("rst.ready", 32'(bus.productReady), 32'd1);
    check("rst.valid", 32'(bus.sumValid), 32'd0);
    check("rst.sum",   32'(bus.sumValue), 32'd0);
    check("rst.count", 32'(bus.sumCount), 32'd0);
    check("rst.ovf",   32'(bus.sumOverflow), 32'd0);

    // 6 + 15 + 9 = 30
    beat(8'd6, 1'b0);
    beat(8'd15, 1'b0);
    check("b1.partial", 32'(bus.sumValue), 32'd21);
    check("b1.no_valid", 32'(bus.sumValid), 32'd0);
    beat(8'd9, 1'b1);
    check_result("b1", 30, 3, 0);
    take_result("b1");

    beat(8'd225, 1'b1);
    check_result("single", 225, 1, 0);
    take_result("single");

    // 19 * 225 = 4275 -> 179 mod 4096, count saturates at 15
    for (int i = 0; i < 19; i++) begin
      beat(8'd225, (i == 18));
    end
    check_result("sat", 179, 15, 1);
    take_result("sat");

    // Back-pressure: result held while upstream keeps offering 50
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b1);
    bus.productValid = 1'b1;
    bus.productValue = 8'd50;
    bus.productLast  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_result("stall", 3, 2, 0);
    end
    bus.sumReady = 1'b1;
    step();
    bus.sumReady = 1'b0;
    check("stall.ready_back", 32'(bus.productReady), 32'd1);
    check("stall.sum_clr",    32'(bus.sumValue), 32'd0);
    check("stall.count_clr",  32'(bus.sumCount), 32'd0);
    step();
    bus.productValid = 1'b0;
    bus.productLast  = 1'b0;
    check_result("after_stall", 50, 1, 0);
    take_result("after_stall");

    // Garbage on idle cycles must be ignored
    bus.productValue = 8'd255;
    bus.productLast  = 1'b1;
    step();
    beat(8'd4, 1'b0);
    bus.productValue = 8'd200;
    bus.productLast  = 1'b1;
    step();
    beat(8'd4, 1'b0);
    bus.productValue = 8'd99;
    bus.productLast  = 1'b1;
    step();
    beat(8'd4, 1'b1);
    check_result("gaps", 12, 3, 0);
    take_result("gaps");

    // sumReady ignored in ACCUM; reset aborts the burst
    bus.sumReady = 1'b1;
    beat(8'd7, 1'b0);
    bus.sumReady = 1'b0;
    check("abort.ignore_sr", 32'(bus.sumValue), 32'd7);
    beat(8'd8, 1'b0);
    check("abort.partial", 32'(bus.sumValue), 32'd15);
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    check("abort.valid", 32'(bus.sumValid), 32'd0);
    check("abort.sum",   32'(bus.sumValue), 32'd0);
    check("abort.count", 32'(bus.sumCount), 32'd0);
    check("abort.ready", 32'(bus.productReady), 32'd1);
    beat(8'd5, 1'b1);
    check_result("post_abort", 5, 1, 0);
    take_result("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
